// File: rtl/btb_pkg.sv
// Shared types and address-split helpers for the BTB write path.
package btb_pkg;

   localparam int BTB_IDX_W = 2;
   localparam int BTB_TAG_W = 28;
   localparam int BTB_TGT_W = 30;

   // One pending BTB write: where it goes and what it stores.
   typedef struct packed {
      logic [BTB_IDX_W-1:0] idx;
      logic [BTB_TAG_W-1:0] tag;
      logic [BTB_TGT_W-1:0] target;
      logic                 active;
   } btb_wr_t;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } btb_ctrl_state_t;

   // Entry index comes from the word-within-line bits of the PC.
   function automatic logic [BTB_IDX_W-1:0] btb_idx(input logic [31:0] pc);
      return pc[3:2];
   endfunction

   // Tag is everything above the index.
   function automatic logic [BTB_TAG_W-1:0] btb_tag(input logic [31:0] pc);
      return pc[31:4];
   endfunction

   // Targets are stored as word addresses; the byte offset is dropped.
   function automatic logic [BTB_TGT_W-1:0] btb_wtgt(input logic [31:0] tgt);
      return tgt[31:2];
   endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Small synchronous FIFO of pending BTB writes with a combinational head.
module btb_upd_fifo
   import btb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic    CLK,
   input  logic    nRST,
   input  logic    push_i,
   input  logic    pop_i,
   input  logic    clr_i,
   input  btb_wr_t din_i,
   output btb_wr_t head_o,
   output logic    full_o,
   output logic    empty_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   btb_wr_t         mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q;
   logic [PW-1:0]   rd_ptr_q;
   logic [CW-1:0]   cnt_q;
   logic            do_push;
   logic            do_pop;

   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign do_push = push_i & ~full_o & ~clr_i;
   assign do_pop  = pop_i & ~empty_o & ~clr_i;
   assign head_o  = mem_q[rd_ptr_q];

   // Storage array: written on push only, no reset needed.
   always_ff @(posedge CLK) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= din_i;
      end
   end

   // Pointers and occupancy; clear empties the queue in one cycle.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/btb_update_ctrl.sv
// Owner of the BTB write port: filters resolved-branch updates, queues them,
// and runs full-table invalidate sweeps that take priority over updates.
module btb_update_ctrl
   import btb_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int NENTRY = 4
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 upd_valid,
   output logic                 upd_ready,
   input  logic [31:0]          upd_pc,
   input  logic [31:0]          upd_target,
   input  logic                 upd_taken,
   input  logic                 upd_hit,
   input  logic                 flush_req,
   output logic                 busy,
   output logic                 btb_wen,
   output logic [BTB_IDX_W-1:0] btb_wsel,
   output logic [BTB_TAG_W-1:0] btb_tag_n,
   output logic [BTB_TGT_W-1:0] btb_target_n,
   output logic                 btb_active_n
);

   localparam logic [BTB_IDX_W-1:0] LAST_IDX = BTB_IDX_W'(NENTRY - 1);

   btb_ctrl_state_t      state_q, state_d;
   logic [BTB_IDX_W-1:0] sweep_idx_q, sweep_idx_d;
   logic                 wen_q, wen_d;
   btb_wr_t              wr_q, wr_d;

   logic                 fifo_full, fifo_empty;
   logic                 fifo_push, fifo_pop, fifo_clr;
   btb_wr_t              fifo_head;
   btb_wr_t              push_rec;
   logic                 push_want;
   logic                 unused_addr_bits;

   // Byte-offset bits of PC and target carry no information for the BTB.
   assign unused_addr_bits = ^{upd_pc[1:0], upd_target[1:0]};

   assign upd_ready = ~fifo_full & ~flush_req;
   assign busy      = (state_q == SWEEP) | ~fifo_empty;

   // Not-taken branches that missed leave nothing to correct, so only
   // taken branches (install) and not-taken hits (evict) produce a write.
   assign push_want       = upd_valid & upd_ready & (upd_taken | upd_hit);
   assign push_rec.idx    = btb_idx(upd_pc);
   assign push_rec.tag    = btb_tag(upd_pc);
   assign push_rec.target = upd_taken ? btb_wtgt(upd_target) : '0;
   assign push_rec.active = upd_taken;

   btb_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK     (CLK),
      .nRST    (nRST),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .clr_i   (fifo_clr),
      .din_i   (push_rec),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Next-state and write selection; an update arriving at an empty FIFO in
   // IDLE bypasses the queue so it is written on the very next cycle.
   always_comb begin
      state_d     = state_q;
      sweep_idx_d = sweep_idx_q;
      fifo_push   = 1'b0;
      fifo_pop    = 1'b0;
      fifo_clr    = 1'b0;
      wen_d       = 1'b0;
      wr_d        = '0;
      case (state_q)
         IDLE: begin
            if (flush_req) begin
               state_d     = SWEEP;
               sweep_idx_d = '0;
               fifo_clr    = 1'b1;
            end else if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               fifo_push = push_want;
               wen_d     = 1'b1;
               wr_d      = fifo_head;
            end else if (push_want) begin
               wen_d = 1'b1;
               wr_d  = push_rec;
            end
         end
         SWEEP: begin
            if (flush_req) begin
               sweep_idx_d = '0;
               fifo_clr    = 1'b1;
            end else begin
               fifo_push = push_want;
               wen_d     = 1'b1;
               wr_d.idx  = sweep_idx_q;
               if (sweep_idx_q == LAST_IDX) begin
                  state_d = IDLE;
               end else begin
                  sweep_idx_d = sweep_idx_q + BTB_IDX_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, sweep index and write-port registers; data holds between writes.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= IDLE;
         sweep_idx_q <= '0;
         wen_q       <= 1'b0;
         wr_q        <= '0;
      end else begin
         state_q     <= state_d;
         sweep_idx_q <= sweep_idx_d;
         wen_q       <= wen_d;
         if (wen_d) begin
            wr_q <= wr_d;
         end
      end
   end

   assign btb_wen      = wen_q;
   assign btb_wsel     = wr_q.idx;
   assign btb_tag_n    = wr_q.tag;
   assign btb_target_n = wr_q.target;
   assign btb_active_n = wr_q.active;

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl: vector table plus sweep/reset sequences.
module tb_btb_update_ctrl;

   logic        CLK;
   logic        nRST;
   logic        upd_valid;
   logic        upd_ready;
   logic [31:0] upd_pc;
   logic [31:0] upd_target;
   logic        upd_taken;
   logic        upd_hit;
   logic        flush_req;
   logic        busy;
   logic        btb_wen;
   logic [1:0]  btb_wsel;
   logic [27:0] btb_tag_n;
   logic [29:0] btb_target_n;
   logic        btb_active_n;

   int n_checks;
   int n_errors;

   btb_update_ctrl #(.DEPTH(2), .NENTRY(4)) dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .upd_valid    (upd_valid),
      .upd_ready    (upd_ready),
      .upd_pc       (upd_pc),
      .upd_target   (upd_target),
      .upd_taken    (upd_taken),
      .upd_hit      (upd_hit),
      .flush_req    (flush_req),
      .busy         (busy),
      .btb_wen      (btb_wen),
      .btb_wsel     (btb_wsel),
      .btb_tag_n    (btb_tag_n),
      .btb_target_n (btb_target_n),
      .btb_active_n (btb_active_n)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] tgt;
      logic        taken;
      logic        hit;
      logic        exp_ready;
      logic        exp_wen;
      logic [1:0]  exp_wsel;
      logic [27:0] exp_tag;
      logic [29:0] exp_tgt;
      logic        exp_act;
      logic        exp_busy;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_in();
      upd_valid  = 1'b0;
      upd_pc     = '0;
      upd_target = '0;
      upd_taken  = 1'b0;
      upd_hit    = 1'b0;
      flush_req  = 1'b0;
   endtask

   task automatic drive_upd(input logic [31:0] pc, input logic [31:0] tgt,
                            input logic taken, input logic hit);
      upd_valid  = 1'b1;
      upd_pc     = pc;
      upd_target = tgt;
      upd_taken  = taken;
      upd_hit    = hit;
      flush_req  = 1'b0;
   endtask

   task automatic chk_wr(input string name, input logic wen, input logic [1:0] wsel,
                         input logic [27:0] tag, input logic [29:0] tgt, input logic act);
      chk({name, ".wen"}, 64'(btb_wen), 64'(wen));
      if (wen) begin
         chk({name, ".wsel"}, 64'(btb_wsel), 64'(wsel));
         chk({name, ".tag"}, 64'(btb_tag_n), 64'(tag));
         chk({name, ".tgt"}, 64'(btb_target_n), 64'(tgt));
         chk({name, ".act"}, 64'(btb_active_n), 64'(act));
      end
      $display("txn %s: wen=%b wsel=%0d tag=0x%0h tgt=0x%0h act=%b busy=%b",
               name, btb_wen, btb_wsel, btb_tag_n, btb_target_n, btb_active_n, busy);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;

      //                valid pc            tgt           tk hit rdy wen wsel tag          tgt           act busy
      vecs[0] = '{1'b1, 32'h0000_1008, 32'h0000_2000, 1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 28'h0000100, 30'h0000800,  1'b1, 1'b0};
      vecs[1] = '{1'b1, 32'h0000_000C, 32'h0000_1234, 1'b0, 1'b1, 1'b1, 1'b1, 2'd3, 28'h0000000, 30'h0000000,  1'b0, 1'b0};
      vecs[2] = '{1'b1, 32'h0000_010C, 32'h0000_5678, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 28'h0000000, 30'h0000000,  1'b0, 1'b0};
      vecs[3] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 28'h0000000, 30'h0000000,  1'b0, 1'b0};
      vecs[4] = '{1'b1, 32'h0000_0104, 32'h0000_3004, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 28'h0000010, 30'h0000C01,  1'b1, 1'b0};
      vecs[5] = '{1'b1, 32'h0000_0208, 32'h0000_4003, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 28'h0000020, 30'h0001000,  1'b1, 1'b0};
      vecs[6] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 28'hFFFFFFF, 30'h3FFFFFFE, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 28'hFFFFFFF, 30'h3FFFFFFE, 1'b1, 1'b0};

      // Reset values are visible while nRST is held, before any clock edge.
      idle_in();
      nRST = 1'b0;
      #1;
      chk("rst.wen",   64'(btb_wen), 64'd0);
      chk("rst.wsel",  64'(btb_wsel), 64'd0);
      chk("rst.tag",   64'(btb_tag_n), 64'd0);
      chk("rst.tgt",   64'(btb_target_n), 64'd0);
      chk("rst.act",   64'(btb_active_n), 64'd0);
      chk("rst.busy",  64'(busy), 64'd0);
      chk("rst.ready", 64'(upd_ready), 64'd1);
      step();
      #3 nRST = 1'b1;
      step();

      // Table: single updates, filtering, and back-to-back stream.
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].valid) drive_upd(vecs[i].pc, vecs[i].tgt, vecs[i].taken, vecs[i].hit);
         else idle_in();
         #1;
         chk($sformatf("vec%0d.ready", i), 64'(upd_ready), 64'(vecs[i].exp_ready));
         step();
         chk($sformatf("vec%0d.wen", i),  64'(btb_wen), 64'(vecs[i].exp_wen));
         chk($sformatf("vec%0d.wsel", i), 64'(btb_wsel), 64'(vecs[i].exp_wsel));
         chk($sformatf("vec%0d.tag", i),  64'(btb_tag_n), 64'(vecs[i].exp_tag));
         chk($sformatf("vec%0d.tgt", i),  64'(btb_target_n), 64'(vecs[i].exp_tgt));
         chk($sformatf("vec%0d.act", i),  64'(btb_active_n), 64'(vecs[i].exp_act));
         chk($sformatf("vec%0d.busy", i), 64'(busy), 64'(vecs[i].exp_busy));
         $display("txn vec%0d: wen=%b wsel=%0d tag=0x%0h tgt=0x%0h act=%b",
                  i, btb_wen, btb_wsel, btb_tag_n, btb_target_n, btb_active_n);
      end

      // Sweep with two queued updates, FIFO full, restart on 3rd sweep cycle.
      idle_in();
      flush_req = 1'b1;
      #1;
      chk("sw1.flush_ready", 64'(upd_ready), 64'd0);
      step();
      chk_wr("sw1.gap", 1'b0, 2'd0, '0, '0, 1'b0);
      chk("sw1.busy0", 64'(busy), 64'd1);
      drive_upd(32'h0000_1008, 32'h0000_2000, 1'b1, 1'b0);
      #1;
      chk("sw1.ready_q1", 64'(upd_ready), 64'd1);
      step();
      chk_wr("sw1.w0", 1'b1, 2'd0, '0, '0, 1'b0);
      drive_upd(32'h0000_0104, 32'h0000_3004, 1'b1, 1'b0);
      #1;
      chk("sw1.ready_q2", 64'(upd_ready), 64'd1);
      step();
      chk_wr("sw1.w1", 1'b1, 2'd1, '0, '0, 1'b0);
      drive_upd(32'h0000_0208, 32'h0000_4000, 1'b1, 1'b0);
      #1;
      chk("sw1.ready_full", 64'(upd_ready), 64'd0);
      flush_req = 1'b1;
      step();
      chk_wr("sw1.restart_gap", 1'b0, 2'd0, '0, '0, 1'b0);
      idle_in();
      #1;
      chk("sw1.ready_cleared", 64'(upd_ready), 64'd1);
      for (int k = 0; k < 4; k++) begin
         step();
         chk_wr($sformatf("sw1.r%0d", k), 1'b1, 2'(k), '0, '0, 1'b0);
         chk($sformatf("sw1.r%0d.busy", k), 64'(busy), (k == 3) ? 64'd0 : 64'd1);
      end
      step();
      chk_wr("sw1.discarded", 1'b0, 2'd0, '0, '0, 1'b0);

      // Sweep with an update accepted mid-sweep, written once the sweep ends.
      flush_req = 1'b1;
      step();
      chk_wr("sw2.gap", 1'b0, 2'd0, '0, '0, 1'b0);
      drive_upd(32'h0000_2004, 32'h0000_5000, 1'b1, 1'b0);
      step();
      chk_wr("sw2.w0", 1'b1, 2'd0, '0, '0, 1'b0);
      idle_in();
      for (int k = 1; k < 4; k++) begin
         step();
         chk_wr($sformatf("sw2.w%0d", k), 1'b1, 2'(k), '0, '0, 1'b0);
      end
      chk("sw2.busy_pending", 64'(busy), 64'd1);
      step();
      chk_wr("sw2.late_upd", 1'b1, 2'd1, 28'h0000200, 30'h0001400, 1'b1);
      chk("sw2.busy_done", 64'(busy), 64'd0);
      step();
      chk_wr("sw2.quiet", 1'b0, 2'd0, '0, '0, 1'b0);

      // Asynchronous reset in the middle of a sweep.
      flush_req = 1'b1;
      step();
      idle_in();
      step();
      chk_wr("rs.w0", 1'b1, 2'd0, '0, '0, 1'b0);
      drive_upd(32'h0000_1008, 32'h0000_2000, 1'b1, 1'b0);
      #1;
      nRST = 1'b0;
      #1;
      chk("rs.wen",   64'(btb_wen), 64'd0);
      chk("rs.wsel",  64'(btb_wsel), 64'd0);
      chk("rs.tag",   64'(btb_tag_n), 64'd0);
      chk("rs.tgt",   64'(btb_target_n), 64'd0);
      chk("rs.act",   64'(btb_active_n), 64'd0);
      chk("rs.busy",  64'(busy), 64'd0);
      chk("rs.ready", 64'(upd_ready), 64'd1);
      idle_in();
      step();
      #2 nRST = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("rs.after%0d.wen", k), 64'(btb_wen), 64'd0);
         chk($sformatf("rs.after%0d.busy", k), 64'(busy), 64'd0);
         chk($sformatf("rs.after%0d.ready", k), 64'(upd_ready), 64'd1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
